// File: rtl/vslc_scan_sequencer_if.sv
// Handshake/bus bundle between the scan sequencer and its host (loader, run control, executor).
interface vslc_scan_sequencer_if #(
  parameter int DEPTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          load_en;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          run;
  logic [7:0]    ui_in;
  logic [7:0]    instr;
  logic          instr_ready;
  logic [7:0]    ui_snap;
  logic [7:0]    ui_prev;
  logic [LW-1:0] prog_len;
  logic [15:0]   scan_count;
  logic          busy;
  logic          load_err;

  modport master (
    output load_en, load_valid, load_data, run, ui_in,
    input  instr, instr_ready, ui_snap, ui_prev, prog_len, scan_count, busy, load_err
  );

  modport slave (
    input  load_en, load_valid, load_data, run, ui_in,
    output instr, instr_ready, ui_snap, ui_prev, prog_len, scan_count, busy, load_err
  );
endinterface

// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle sequencer: byte-serial program load, per-scan input snapshot and one-instruction-per-cycle replay.
//   state | meaning
//   IDLE  | waiting for run with a loaded program and no load in progress
//   SNAP  | latch ui_in into ui_snap, shift old snapshot into ui_prev, rewind pc
//   CLR   | issue the stack-clear instruction 8'hF0
//   ISSUE | issue mem[pc] each cycle until the last program byte
//   GAP   | enforced idle cycles; completed scan is counted on the first one
module vslc_scan_sequencer #(
  parameter int DEPTH       = 32,
  parameter int SCAN_GAP    = 4,
  parameter int CLR_ON_SCAN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vslc_scan_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SNAP, CLR, ISSUE, GAP} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    instr;
  logic          instr_ready;
  logic [7:0]    ui_snap;
  logic [7:0]    ui_prev;
  logic [LW-1:0] prog_len;
  logic [15:0]   scan_count;
  logic          load_err;
  logic          load_en_d;
  logic [7:0]    mem [DEPTH];

  logic          load_rise;
  logic [LW-1:0] wr_ptr;
  logic          wr_ok;
  logic          last_issue;

  // A byte arriving on the rising-edge cycle lands at address 0 of the fresh program.
  assign load_rise  = bus.load_en & ~load_en_d;
  assign wr_ptr     = load_rise ? '0 : prog_len;
  assign wr_ok      = bus.load_en & bus.load_valid & (wr_ptr != LW'(DEPTH));
  assign last_issue = ({1'b0, pc} == (prog_len - LW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_en_d <= 1'b0;
      prog_len  <= '0;
      load_err  <= 1'b0;
    end else begin
      load_en_d <= bus.load_en;
      if (load_rise) begin
        prog_len <= '0;
        load_err <= 1'b0;
      end
      if (bus.load_en && bus.load_valid) begin
        if (wr_ok) prog_len <= wr_ptr + LW'(1);
        else       load_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      gap_cnt     <= '0;
      instr       <= 8'h00;
      instr_ready <= 1'b0;
      ui_snap     <= 8'h00;
      ui_prev     <= 8'h00;
      scan_count  <= 16'h0000;
    end else if (state != IDLE && bus.load_en) begin
      // Loading aborts the scan in flight; it is not counted and snapshots hold.
      state       <= IDLE;
      instr_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready <= 1'b0;
          if (bus.run && !bus.load_en && prog_len != '0) state <= SNAP;
        end
        SNAP: begin
          ui_prev     <= ui_snap;
          ui_snap     <= bus.ui_in;
          pc          <= '0;
          instr_ready <= 1'b0;
          state       <= (CLR_ON_SCAN != 0) ? CLR : ISSUE;
        end
        CLR: begin
          instr       <= 8'hF0;
          instr_ready <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          instr       <= mem[pc];
          instr_ready <= 1'b1;
          pc          <= pc + 1'b1;
          if (last_issue) begin
            state   <= GAP;
            gap_cnt <= GW'(SCAN_GAP - 1);
          end
        end
        GAP: begin
          instr_ready <= 1'b0;
          if (gap_cnt == GW'(SCAN_GAP - 1)) scan_count <= scan_count + 16'd1;
          if (gap_cnt == '0) state <= bus.run ? SNAP : IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr       = instr;
  assign bus.instr_ready = instr_ready;
  assign bus.ui_snap     = ui_snap;
  assign bus.ui_prev     = ui_prev;
  assign bus.prog_len    = prog_len;
  assign bus.scan_count  = scan_count;
  assign bus.busy        = (state != IDLE);
  assign bus.load_err    = load_err;
endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Scoreboard bench for vslc_scan_sequencer: expected pulses are queued from a scan-level model, a monitor compares them.
module tb_vslc_scan_sequencer;
  localparam int DEPTH       = 8;
  localparam int SCAN_GAP    = 4;
  localparam int CLR_ON_SCAN = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vslc_scan_sequencer_if #(.DEPTH(DEPTH)) bus ();

  vslc_scan_sequencer #(
    .DEPTH(DEPTH), .SCAN_GAP(SCAN_GAP), .CLR_ON_SCAN(CLR_ON_SCAN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  instr;
    logic [7:0]  snap;
    logic [7:0]  prev;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  logic [7:0]  m_prog[$];
  logic [7:0]  q_load[$];
  logic [7:0]  m_snap = 8'h00;
  logic [7:0]  m_prev = 8'h00;
  logic [15:0] m_count = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got instr %0h expected no pulse at cycle %0d", bus.instr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("instr", bus.instr, mon_e.instr);
        check("ui_snap", bus.ui_snap, mon_e.snap);
        check("ui_prev", bus.ui_prev, mon_e.prev);
        check("scan_count", bus.scan_count, mon_e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] ins);
    exp_t e;
    e.cyc = c; e.instr = ins; e.snap = m_snap; e.prev = m_prev; e.cnt = m_count;
    exp_q.push_back(e);
  endtask

  // Called during the SNAP cycle: snapshot rule plus the whole scan's pulse stream.
  task automatic begin_scan(output int x);
    x = cyc;
    m_prev = m_snap;
    m_snap = bus.ui_in;
    if (CLR_ON_SCAN != 0) push(x + 2, 8'hF0);
    foreach (m_prog[i]) push(x + 2 + CLR_ON_SCAN + i, m_prog[i]);
  endtask

  task automatic rand_prog(input int n);
    q_load.delete();
    repeat (n) q_load.push_back(8'($urandom));
  endtask

  task automatic load_prog();
    int n = q_load.size();
    m_prog.delete();
    bus.load_en = 1'b1;
    tick();
    foreach (q_load[i]) begin
      bus.load_valid = 1'b1;
      bus.load_data  = q_load[i];
      if (m_prog.size() < DEPTH) m_prog.push_back(q_load[i]);
      tick();
    end
    bus.load_valid = 1'b0;
    check("prog_len_loaded", bus.prog_len, (n > DEPTH) ? DEPTH : n);
    check("load_err_loaded", bus.load_err, (n > DEPTH) ? 1 : 0);
    bus.load_en = 1'b0;
    tick();
  endtask

  task automatic run_scans(input int n, input bit rand_ui, input bit dir_ui, input int drop_j);
    int L = m_prog.size();
    int period = 1 + CLR_ON_SCAN + L + SCAN_GAP;
    int x;
    bus.run = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      begin_scan(x);
      for (int j = 1; j <= period; j++) begin
        tick();
        if (j == 1) begin
          check("snap_after_snap", bus.ui_snap, m_snap);
          check("prev_after_snap", bus.ui_prev, m_prev);
        end
        if (j == 2 + CLR_ON_SCAN + L) begin
          m_count = m_count + 16'd1;
          check("gap_ready_low", bus.instr_ready, 0);
          check("count_at_gap", bus.scan_count, m_count);
        end
        if (k == n - 1 && j == drop_j) bus.run = 1'b0;
        if (k == n - 1 && j == period - 1) check("busy_last_gap", bus.busy, 1);
        if (k == n - 1 && j == period) check("idle_after_gap", bus.busy, 0);
        if (rand_ui && $urandom_range(0, 3) == 0) bus.ui_in = 8'($urandom);
        if (dir_ui && j == 3) bus.ui_in = 8'h03;
      end
    end
  endtask

  initial begin
    int x;
    bus.load_en = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00;
    bus.run = 1'b0; bus.ui_in = 8'h00;
    #3;
    check("rst_data", {bus.instr, bus.ui_snap, bus.ui_prev}, 0);
    check("rst_ctrl", {bus.prog_len, bus.scan_count, bus.instr_ready, bus.busy, bus.load_err}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Run with nothing loaded must not start.
    bus.run = 1'b1;
    repeat (6) tick();
    check("empty_no_start", bus.busy, 0);
    bus.run = 1'b0;
    tick();

    // Directed program, ui change mid-ISSUE, run dropped during byte 2 of the last scan.
    q_load.delete();
    q_load.push_back(8'h80); q_load.push_back(8'h91); q_load.push_back(8'hA2);
    load_prog();
    bus.ui_in = 8'h01;
    run_scans(3, 1'b0, 1'b1, 3);
    tick();

    // Random programs and inputs.
    repeat (3) begin
      rand_prog($urandom_range(1, DEPTH));
      load_prog();
      run_scans($urandom_range(1, 3), 1'b1, 1'b0, $urandom_range(1, 3));
      tick();
    end

    // Overflow: DEPTH+2 bytes, full-depth program still replays, next rise clears.
    rand_prog(DEPTH + 2);
    load_prog();
    run_scans(2, 1'b1, 1'b0, 3);
    bus.load_en = 1'b1;
    tick();
    check("ovf_len_cleared", bus.prog_len, 0);
    check("ovf_err_cleared", bus.load_err, 0);
    bus.load_en = 1'b0;
    tick();

    // load_en during ISSUE aborts without counting.
    rand_prog(3);
    load_prog();
    bus.ui_in = 8'($urandom);
    bus.run = 1'b1;
    tick();
    begin_scan(x);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (3) tick();
    bus.load_en = 1'b1;
    tick();
    check("abort_ready_low", bus.instr_ready, 0);
    check("abort_idle", bus.busy, 0);
    check("abort_count_held", bus.scan_count, m_count);
    check("abort_snap_held", bus.ui_snap, m_snap);
    check("abort_prev_held", bus.ui_prev, m_prev);
    repeat (3) tick();
    check("load_and_run_idle", bus.busy, 0);
    bus.load_en = 1'b0;
    repeat (5) tick();
    check("zero_len_run_idle", bus.busy, 0);
    bus.run = 1'b0;
    tick();

    // Asynchronous reset during CLR.
    rand_prog(2);
    load_prog();
    bus.ui_in = 8'h5A;
    bus.run = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", {bus.instr, bus.ui_snap, bus.ui_prev}, 0);
    check("async_rst_ctrl", {bus.prog_len, bus.scan_count, bus.instr_ready, bus.busy, bus.load_err}, 0);
    m_count = 16'h0000; m_snap = 8'h00; m_prev = 8'h00; m_prog.delete();
    bus.run = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    rand_prog(2);
    load_prog();
    run_scans(2, 1'b1, 1'b0, 3);

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vslc_scan_sequencer.md
# vslc_scan_sequencer

Scan-cycle sequencer that feeds the VSLC executor. It stores a small program loaded byte-serially, replays it as one-instruction-per-cycle `instr`/`instr_ready` pulses, and snapshots `ui_in` at the start of each scan so that `ui_in_prev` edge detection is scan-coherent. It optionally injects a stack-clear instruction at scan start, counts completed scans and enforces a minimum idle gap between scans.

## Interface
Parameters:
- `DEPTH`, 32: program memory size in bytes (power of 2, 4..256).
- `SCAN_GAP`, 4: idle cycles between scans, min 1.
- `CLR_ON_SCAN`, 1: when 1, issue `8'hF0` (stack clear) as the first instruction of every scan.

Ports (one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_en`  in  1  load mode; a rising edge clears the write pointer, `prog_len` and `load_err`.
- `load_valid`  in  1  qualifies `load_data`; honoured only while `load_en`=1.
- `load_data`  in  8  program byte.
- `run`  in  1  level; enables continuous scanning.
- `ui_in`  in  8  raw inputs.
- `instr`  out  8  instruction to executor (registered).
- `instr_ready`  out  1  one-cycle qualifier per instruction (registered).
- `ui_snap`  out  8  inputs latched at scan start (drives executor `ui_in`).
- `ui_prev`  out  8  previous scan's `ui_snap` (drives executor `ui_in_prev`).
- `prog_len`  out  $clog2(DEPTH)+1  bytes loaded.
- `scan_count`  out  16  completed scans, wraps at 16'hFFFF to 0.
- `busy`  out  1  high in every state except IDLE.
- `load_err`  out  1  sticky overflow flag.

## Operation
- Reset values: `instr`=0, `instr_ready`=0, `ui_snap`=0, `ui_prev`=0, `prog_len`=0, `scan_count`=0, `busy`=0, `load_err`=0, write pointer=0, pc=0, state=IDLE. Memory contents are not reset.
- Load: while `load_en`=1 and `load_valid`=1, write `load_data` to mem[wp], then wp++ and `prog_len`++.
  - If wp==DEPTH, drop the byte and set `load_err`.
  - `load_err` stays set until the next `load_en` rising edge or reset.
- States: IDLE, SNAP, CLR, ISSUE, GAP.
- IDLE: if `run`=1, `load_en`=0 and `prog_len`!=0, go to SNAP. Otherwise stay.
- SNAP (1 cycle): `ui_prev`<=`ui_snap`, `ui_snap`<=`ui_in`, pc<=0. Go to CLR if CLR_ON_SCAN, else ISSUE.
- CLR (1 cycle): `instr`<=8'hF0, `instr_ready`<=1. Go to ISSUE.
- ISSUE: `instr`<=mem[pc], `instr_ready`<=1, pc++.
  - After issuing pc==`prog_len`-1: go to GAP and increment `scan_count`.
- GAP: `instr_ready`=0 for SCAN_GAP cycles. Then go to SNAP if `run`=1, else IDLE.
- `run` dropping mid-scan: the current scan completes, including the count increment and GAP, then IDLE.
- `load_en`=1 in any non-IDLE state: next state is IDLE and `instr_ready`=0 from the next cycle.
  - The partial scan is not counted.
  - `ui_snap`/`ui_prev` hold.
- `load_en` and `run` both high: load wins and the sequencer stays IDLE.
- `instr` holds its last value when `instr_ready`=0.

## Timing
- `run` sampled high in IDLE at edge N:
  - SNAP during cycle N+1; `ui_snap` valid after edge N+1.
  - With CLR_ON_SCAN=1, `instr_ready`=1 with `instr`=F0 after edge N+2, then program bytes after edges N+3 … N+2+L.
- Scan period is 1 + CLR_ON_SCAN + L + SCAN_GAP cycles, where L=`prog_len`.
- `scan_count` updates on the same edge that deasserts `instr_ready` at scan end.
- Outputs are posedge-registered. The executor samples on negedge, so it gets half a cycle of setup.
- `ui_in` is sampled only in SNAP; changes at other times have no effect until the next scan.
- Asynchronous reset mid-scan: all outputs return to reset values immediately. The program must be reloaded before `prog_len`!=0 again.

## Test plan
- Load 3 bytes {80,91,A2}, `run`=1, SCAN_GAP=4, CLR_ON_SCAN=1 -> `instr_ready` pattern per scan is 1,1,1,1 then 0×4, plus 1 SNAP cycle with `instr_ready`=0. `instr` sequence is F0,80,91,A2. Period is 9 cycles and `scan_count` increments once per period.
- `ui_in`=01 for scan 1, then 03 (changed mid-ISSUE) -> scan 2 `ui_snap`=03, `ui_prev`=01. Mid-scan changes are not visible until the next SNAP.
- Load DEPTH+2 bytes -> `prog_len`=DEPTH, `load_err`=1. The next `load_en` rising edge clears both.
- `run` deasserted during ISSUE byte 2 of 3 -> byte 3 is still issued, `scan_count`+1, GAP completes, then IDLE with `busy`=0.
- `load_en` asserted during ISSUE -> `instr_ready`=0 next cycle and `scan_count` unchanged. `prog_len`=0 with `run`=1 -> stays IDLE, no `instr_ready`.
- `rst_n` pulsed low asynchronously mid-CLR -> all outputs 0 immediately without a clock edge.
